mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
//  Sequencer for the multiply/divide unit in the E stage of the 5-stage pipelined core.
//  Accepts one MD operation, computes the product or quotient/remainder, and holds busy
//  for the fixed architectural latency. Commits HI/LO at the end of that latency.
//  Raises the stall request the hazard unit uses to freeze D while an MD instruction waits.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
//  CNT_W        4   counter width; must satisfy 2**CNT_W > max(MULT_CYCLES, DIV_CYCLES)
// PORTS
//  clk        in   1   clock; all state updates on rising edge
//  reset      in   1   synchronous, active-low reset (0 = reset)
//  start      in   1   E-stage MD instruction valid this cycle
//  md_op      in   3   op code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
//  rs_val     in   32  forwarded rs operand
//  rt_val     in   32  forwarded rt operand
//  d_is_md    in   1   D stage holds an MD instruction (mult/div/mthi/mtlo/mfhi/mflo)
//  busy       out  1   a mult/div is in flight
//  stall_md   out  1   d_is_md & (busy | start_long); start_long = start & md_op in 1..4
//  hi         out  32  HI register
//  lo         out  32  LO register
// BEHAVIOUR
//  - Reset (reset==0 at an edge): state IDLE; cnt=0; busy=0; hi=lo=0; pending regs=0.
//    This applies equally when an operation is mid-flight; that operation is discarded.
//  - FSM has two states, IDLE and RUN.
//  - IDLE with start=1 and md_op 1..4:
//    - latch the pending result at this edge: {hi_p,lo_p} = 64-bit signed/unsigned product,
//      or lo_p = quotient and hi_p = remainder (signed ops truncate toward zero);
//    - load cnt = MULT_CYCLES or DIV_CYCLES;
//    - go to RUN; busy=1 from the next cycle.
//  - RUN: cnt decrements each edge. At the edge where cnt==1: hi<=hi_p, lo<=lo_p, busy<=0,
//    go to IDLE. busy is therefore high for exactly N cycles after the start edge, and the
//    new hi/lo are visible the cycle busy falls.
//  - Divide by zero (rt_val==0, DIV/DIVU): full busy latency still applies; hi/lo unchanged at commit.
//  - Signed overflow case (0x80000000 / -1): lo=0x80000000, hi=0.
//  - MTHI/MTLO in IDLE: hi (or lo) <= rs_val at that edge; busy stays 0.
//  - start while busy=1: ignored, with no state change. The pipeline guarantees this via
//    stall_md; a simulation-only $display flags it.
//  - md_op 0 or 7 with start=1: ignored.
//  - stall_md is combinational. It is asserted in the start cycle itself so an MD instruction
//    in D cannot enter E in the same cycle that a mult/div starts.
//  - hi/lo are read combinationally by the E-stage result mux (mfhi/mflo); there is no bypass
//    of pending values.
// STRUCTURE
//  - Shared header mdu_def.v: `define MD_NOP .. MD_MTLO op codes, plus default latencies.
//  - One sub-module, mdu_calc: combinational 64-bit mult/div core,
//    (rs, rt, op) -> {hi_p, lo_p, div0}.
//  - mdu_ctrl contains only the FSM, counter, pending regs and HI/LO regs.
//  - Existing mux2 selects the hi/lo write source (pending vs rs_val).
// TESTING
//  1 reset held 0 for 2 cycles mid-DIV -> busy=0, hi=lo=0, state IDLE on next cycle
//  2 MULT rs=0xFFFFFFFF rt=2 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE
//    MULTU with the same operands -> hi=0x00000001 lo=0xFFFFFFFE
//  3 DIV rs=-7 rt=2 -> busy 10 cycles, then lo=0xFFFFFFFD hi=0xFFFFFFFF;
//    DIVU rs=7 rt=0 -> busy 10 cycles, hi/lo unchanged
//  4 MTHI rs=0x1234 in IDLE -> hi=0x1234 next cycle, busy never set;
//    MTLO issued while busy -> ignored, lo takes the mult result at commit
//  5 d_is_md=1 held across start and RUN -> stall_md=1 from the start cycle until the cycle
//    busy falls, then 0
//  6 back-to-back MULT issued in the cycle after commit -> accepted; second result overwrites
//    hi/lo 5 cycles later

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// default latencies and the calculator result payload.
package mdu_ctrl_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned OP_W            = 3;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W_DEF       = 4;

  typedef enum logic [OP_W-1:0] {
    MD_NOP   = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              div0;
  } calc_res_t;

  // Ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_long_op(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult_op(input logic [OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit multiply / 32-bit divide core producing the pending
// HI/LO pair and a divide-by-zero flag.
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  input  logic [OP_W-1:0]   op,
  output calc_res_t         res
);

  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic                signed_div;
  logic                rs_neg;
  logic                rt_neg;
  logic [DATA_W-1:0]   rs_mag;
  logic [DATA_W-1:0]   rt_mag;
  logic [DATA_W-1:0]   divisor;
  logic [DATA_W-1:0]   quo_u;
  logic [DATA_W-1:0]   rem_u;
  calc_res_t           res_c;

  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly.
  always_comb begin
    prod_s     = $signed({{DATA_W{rs[DATA_W-1]}}, rs}) * $signed({{DATA_W{rt[DATA_W-1]}}, rt});
    prod_u     = {{DATA_W{1'b0}}, rs} * {{DATA_W{1'b0}}, rt};
    signed_div = (op == MD_DIV);
    rs_neg     = signed_div & rs[DATA_W-1];
    rt_neg     = signed_div & rt[DATA_W-1];
    rs_mag     = rs_neg ? (DATA_W'(0) - rs) : rs;
    rt_mag     = rt_neg ? (DATA_W'(0) - rt) : rt;
    divisor    = (rt_mag == '0) ? DATA_W'(1) : rt_mag;
    quo_u      = rs_mag / divisor;
    rem_u      = rs_mag % divisor;
  end

  always_comb begin
    res_c = '0;
    case (op)
      MD_MULT:  {res_c.hi, res_c.lo} = prod_s;
      MD_MULTU: {res_c.hi, res_c.lo} = prod_u;
      MD_DIV, MD_DIVU: begin
        res_c.lo   = (rs_neg ^ rt_neg) ? (DATA_W'(0) - quo_u) : quo_u;
        res_c.hi   = rs_neg ? (DATA_W'(0) - rem_u) : rem_u;
        res_c.div0 = (rt == '0);
      end
      default: res_c = '0;
    endcase
  end

  assign res = res_c;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: holds busy for the fixed latency, commits HI/LO
// at the end of it, and requests a D-stage stall for dependent MD instructions.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   md_op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              d_is_md,
  output logic              busy,
  output logic              stall_md,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hi_p;
  logic [DATA_W-1:0] lo_p;
  logic              pend_wr;
  calc_res_t         calc;

  logic              start_long;
  logic              accept_long;
  logic              commit;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] hi_wd;
  logic [DATA_W-1:0] lo_wd;

  mdu_calc u_calc (
    .rs  (rs_val),
    .rt  (rt_val),
    .op  (md_op),
    .res (calc)
  );

  assign start_long  = start & is_long_op(md_op);
  assign accept_long = (state == IDLE) & start_long;
  assign commit      = (state == RUN) & (cnt == CNT_W'(1));
  assign stall_md    = d_is_md & (busy | start_long);

  // HI/LO write source: pending result at commit, otherwise rs_val for MTHI/MTLO.
  always_comb begin
    hi_we = 1'b0;
    lo_we = 1'b0;
    hi_wd = commit ? hi_p : rs_val;
    lo_wd = commit ? lo_p : rs_val;
    if (commit) begin
      hi_we = pend_wr;
      lo_we = pend_wr;
    end else if ((state == IDLE) && start) begin
      hi_we = (md_op == MD_MTHI);
      lo_we = (md_op == MD_MTLO);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi_p    <= '0;
      lo_p    <= '0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_long) begin
            hi_p    <= calc.hi;
            lo_p    <= calc.lo;
            pend_wr <= ~calc.div0;
            cnt     <= is_mult_op(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (commit) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (hi_we) hi <= hi_wd;
      if (lo_we) lo <= lo_wd;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed vectors plus randomized op streams
// checked against an arithmetic HI/LO model.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          mt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          busy_start = 0;
  int          busy_free = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result of one MD op, from plain 64-bit arithmetic.
  function automatic logic [63:0] model_op(input int op, input logic [31:0] rs, input logic [31:0] rt,
                                           input logic [31:0] h, input logic [31:0] l);
    longint          a, b, q, r;
    longint unsigned pu;
    logic [31:0]     nh, nl;
    nh = h;
    nl = l;
    case (op)
      1: begin
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        q = a * b;
        nh = q[63:32];
        nl = q[31:0];
      end
      2: begin
        pu = 64'(rs) * 64'(rt);
        nh = pu[63:32];
        nl = pu[31:0];
      end
      3: if (rt != 0) begin
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        q = a / b;
        r = a % b;
        nl = q[31:0];
        nh = r[31:0];
      end
      4: if (rt != 0) begin
        nl = rs / rt;
        nh = rs % rt;
      end
      5: nh = rs;
      6: nl = rs;
      default: ;
    endcase
    return {nh, nl};
  endfunction

  // Model of a start presented this cycle; ignored while the unit is occupied.
  task automatic model_start(input int op, input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    if (cyc < busy_free) return;
    if (op >= 1 && op <= 6) begin
      {m_hi, m_lo} = model_op(op, rs, rt, m_hi, m_lo);
      e.hi = m_hi;
      e.lo = m_lo;
      if (op <= 4) begin
        busy_start = cyc + 1;
        busy_free  = cyc + 1 + ((op <= 2) ? MULT_N : DIV_N);
        e.mt  = 1'b0;
        e.due = busy_free;
      end else begin
        e.mt  = 1'b1;
        e.due = cyc + 1;
      end
      sb.push_back(e);
    end
  endtask

  task automatic drive(input int op, input logic [31:0] rs, input logic [31:0] rt);
    start  = 1'b1;
    md_op  = 3'(op);
    rs_val = rs;
    rt_val = rt;
    model_start(op, rs, rt);
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
  endtask

  task automatic wait_idle();
    while (cyc < busy_free) @(negedge clk);
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    m_hi       = '0;
    m_lo       = '0;
    busy_start = 0;
    busy_free  = 0;
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: per-cycle busy/stall checks, pops scoreboard on MT writes and commits.
  initial begin : monitor
    logic prev_busy;
    logic prev_rst;
    logic mbusy;
    logic exp_stall;
    exp_t e;
    prev_busy = 1'b0;
    prev_rst  = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        prev_busy = 1'b0;
        prev_rst  = 1'b0;
      end else begin
        if (!prev_rst) begin
          chk("reset_busy", 32'(busy), 32'h0);
          chk("reset_hi", hi, 32'h0);
          chk("reset_lo", lo, 32'h0);
        end
        mbusy     = (cyc >= busy_start) && (cyc < busy_free);
        exp_stall = d_is_md && (mbusy || (start && md_op >= 3'd1 && md_op <= 3'd4));
        chk("busy", 32'(busy), 32'(mbusy));
        chk("stall_md", 32'(stall_md), 32'(exp_stall));
        while (sb.size() > 0 && sb[0].mt && sb[0].due <= cyc) begin
          e = sb.pop_front();
          chk("mt_hi", hi, e.hi);
          chk("mt_lo", lo, e.lo);
        end
        if (prev_busy && !busy) begin
          if (sb.size() == 0 || sb[0].mt) begin
            checks++;
            errors++;
            $display("FAIL commit_unexpected: busy fell with no pending op (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk("commit_hi", hi, e.hi);
            chk("commit_lo", lo, e.lo);
            chk("commit_cycle", 32'(cyc), 32'(e.due));
          end
        end
        prev_busy = busy;
        prev_rst  = 1'b1;
      end
    end
  end

  initial begin : stim
    int guard;
    reset   = 1'b0;
    start   = 1'b0;
    md_op   = 3'd0;
    rs_val  = '0;
    rt_val  = '0;
    d_is_md = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    d_is_md = 1'b1;
    drive(1, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    d_is_md = 1'b0;
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    drive(2, 32'hFFFF_FFFF, 32'd2);
    wait_idle();
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    drive(3, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);

    drive(4, 32'd7, 32'd0);
    wait_idle();
    chk("divu0_hi", hi, 32'hFFFF_FFFF);
    chk("divu0_lo", lo, 32'hFFFF_FFFD);

    drive(3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    chk("divovf_hi", hi, 32'h0);
    chk("divovf_lo", lo, 32'h8000_0000);

    drive(5, 32'h1234, 32'd0);
    chk("mthi", hi, 32'h1234);
    drive(6, 32'hABCD, 32'd0);
    chk("mtlo", lo, 32'hABCD);

    drive(1, 32'd3, 32'd4);
    drive(6, 32'h5555, 32'd0);
    wait_idle();
    chk("mtlo_busy_hi", hi, 32'h0);
    chk("mtlo_busy_lo", lo, 32'd12);

    drive(1, 32'd5, 32'd6);
    wait_idle();
    chk("b2b_first_lo", lo, 32'd30);
    drive(1, 32'd7, 32'd8);
    wait_idle();
    chk("b2b_second_lo", lo, 32'd56);

    drive(3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    do_reset();
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a, b;
      int          op;
      a       = rand_val();
      b       = rand_val();
      op      = int'($urandom_range(0, 7));
      d_is_md = 1'($urandom_range(0, 1));
      md_op   = 3'(op);
      rs_val  = a;
      rt_val  = b;
      start   = ($urandom_range(0, 2) == 0);
      if (start) model_start(op, a, b);
      @(negedge clk);
    end
    start   = 1'b0;
    md_op   = 3'd0;
    d_is_md = 1'b0;

    guard = 0;
    while (sb.size() > 0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
